// File: rtl/sequenciador_programa.sv
// Program sequencer: holds a loadable program memory and feeds DIN/Run of processador_multiciclo.
// Optional Done watchdog (Erro flag) is compiled in when SEQ_WATCHDOG_EN is defined.
module sequenciador_programa #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Done,
    input  logic              Load_en,
    input  logic [ADDR_W-1:0] Load_addr,
    input  logic [DATA_W-1:0] Load_data,
    output logic [DATA_W-1:0] DIN,
    output logic              Run,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic              Halted,
    output logic              Erro
);
    localparam int         DEPTH   = 1 << ADDR_W;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {OCIOSO, EMITE, IMEDIATO, ESPERA, PARADO} estado_t;

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              run_q, run_d;
    logic              mvi_q, mvi_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              idle, load_ok, start_ok, issue;
    logic [ADDR_W:0]   next_wide;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_word, imm_word;
    logic              fetch_mvi, fetch_halt;

`ifdef SEQ_WATCHDOG_EN
    logic [3:0] wd_q, wd_d;
    logic       erro_q, erro_d;
`endif

    assign idle     = (estado_q == OCIOSO) || (estado_q == PARADO);
    assign load_ok  = idle && Load_en;
    assign start_ok = idle && Start;

    // One extra bit so the end of memory is detected instead of wrapping
    assign next_wide  = {1'b0, pc_q} + (mvi_q ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1));
    assign fetch_addr = idle ? '0 : next_wide[ADDR_W-1:0];

    // Forward a same-cycle load so Start issues the freshly written word
    assign fetch_word = (load_ok && (Load_addr == fetch_addr)) ? Load_data : mem[fetch_addr];
    assign imm_word   = mem[pc_q + ADDR_W'(1)];
    assign fetch_mvi  = (fetch_word[8:6] == OP_MVI);
    assign fetch_halt = (fetch_word[8:6] == OP_HALT) || (fetch_mvi && (fetch_addr == '1));

    always_ff @(posedge Clock) begin
        if (load_ok) begin
            mem[Load_addr] <= Load_data;
        end
    end

    always_comb begin
        estado_d = estado_q;
        pc_d     = pc_q;
        din_d    = din_q;
        run_d    = 1'b0;
        mvi_d    = mvi_q;
        issue    = 1'b0;
`ifdef SEQ_WATCHDOG_EN
        wd_d     = wd_q;
        erro_d   = erro_q;
`endif
        case (estado_q)
            OCIOSO, PARADO: begin
                if (start_ok) begin
                    pc_d  = '0;
                    issue = 1'b1;
`ifdef SEQ_WATCHDOG_EN
                    erro_d = 1'b0;
`endif
                end
            end
            EMITE: begin
                if (mvi_q) begin
                    din_d    = imm_word;
                    estado_d = IMEDIATO;
                end else begin
                    estado_d = ESPERA;
                end
`ifdef SEQ_WATCHDOG_EN
                wd_d = '0;
`endif
            end
            IMEDIATO, ESPERA: begin
                if (Done) begin
                    if (next_wide[ADDR_W]) begin
                        estado_d = PARADO;
                    end else begin
                        pc_d  = next_wide[ADDR_W-1:0];
                        issue = 1'b1;
                    end
                end else begin
                    estado_d = ESPERA;
`ifdef SEQ_WATCHDOG_EN
                    wd_d = wd_q + 4'd1;
                    if (wd_q == 4'd14) begin
                        erro_d   = 1'b1;
                        estado_d = PARADO;
                    end
`endif
                end
            end
            default: estado_d = OCIOSO;
        endcase

        // Fetch decision is made on the edge that enters EMITE so Run is registered
        if (issue) begin
            mvi_d = fetch_mvi;
            if (fetch_halt) begin
                estado_d = PARADO;
            end else begin
                din_d    = fetch_word;
                run_d    = 1'b1;
                estado_d = EMITE;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            estado_q <= OCIOSO;
            pc_q     <= '0;
            din_q    <= '0;
            run_q    <= 1'b0;
            mvi_q    <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            wd_q     <= '0;
            erro_q   <= 1'b0;
`endif
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
            din_q    <= din_d;
            run_q    <= run_d;
            mvi_q    <= mvi_d;
`ifdef SEQ_WATCHDOG_EN
            wd_q     <= wd_d;
            erro_q   <= erro_d;
`endif
        end
    end

    assign DIN    = din_q;
    assign Run    = run_q;
    assign PC     = pc_q;
    assign Busy   = (estado_q == EMITE) || (estado_q == IMEDIATO) || (estado_q == ESPERA);
    assign Halted = (estado_q == PARADO);
`ifdef SEQ_WATCHDOG_EN
    assign Erro   = erro_q;
`else
    assign Erro   = 1'b0;
`endif

endmodule

// File: tb/tb_sequenciador_programa.sv
// Scoreboard bench for sequenciador_programa: expected issues are queued by the stimulus
// and a negedge monitor checks every Run pulse and mvi immediate against them.
module tb_sequenciador_programa;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic          Clock     = 1'b0;
    logic          Resetn    = 1'b0;
    logic          Start     = 1'b0;
    logic          Done      = 1'b0;
    logic          Load_en   = 1'b0;
    logic [AW-1:0] Load_addr = '0;
    logic [DW-1:0] Load_data = '0;
    logic [DW-1:0] DIN;
    logic          Run;
    logic [AW-1:0] PC;
    logic          Busy, Halted, Erro;

    sequenciador_programa #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .Done(Done),
        .Load_en(Load_en), .Load_addr(Load_addr), .Load_data(Load_data),
        .DIN(DIN), .Run(Run), .PC(PC), .Busy(Busy), .Halted(Halted), .Erro(Erro)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] word;
        logic          has_imm;
        logic [DW-1:0] imm;
    } exp_t;

    exp_t          expq[$];
    exp_t          cur;
    logic [DW-1:0] img [DEPTH];
    int            total = 0;
    int            bad   = 0;
    logic          prev_run    = 1'b0;
    logic          imm_pending = 1'b0;
    logic [DW-1:0] imm_exp     = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every Run pulse must match the head of the scoreboard
    always @(negedge Clock) begin
        if (!Resetn) begin
            imm_pending = 1'b0;
        end else if (Run) begin
            chk("run_not_consecutive", {31'b0, prev_run}, 32'd0);
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_run: got Run=1 PC=%0d DIN=%0h expected no issue", PC, DIN);
            end else begin
                cur = expq.pop_front();
                chk("issue_din", {16'b0, DIN}, {16'b0, cur.word});
                chk("issue_pc", {28'b0, PC}, {28'b0, cur.pc});
                imm_pending = cur.has_imm;
                imm_exp     = cur.imm;
            end
        end else if (imm_pending) begin
            chk("imm_din", {16'b0, DIN}, {16'b0, imm_exp});
            imm_pending = 1'b0;
        end
        prev_run = Run;
    end

    task automatic tick();
        @(negedge Clock);
    endtask

    task automatic load(input int a, input logic [DW-1:0] d);
        Load_en   = 1'b1;
        Load_addr = AW'(a);
        Load_data = d;
        img[a]    = d;
        tick();
        Load_en   = 1'b0;
    endtask

    task automatic expect_issue(input int a);
        exp_t ex;
        ex.pc      = AW'(a);
        ex.word    = img[a];
        ex.has_imm = (img[a][8:6] == 3'b001);
        ex.imm     = (a < DEPTH - 1) ? img[a+1] : '0;
        expq.push_back(ex);
    endtask

    task automatic start_pulse();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_issue(input string name);
        int n = 0;
        while (!Run && n < 20) begin
            tick();
            n++;
        end
        chk(name, {31'b0, Run}, 32'd1);
    endtask

    task automatic step_done();
        tick();
        Done = 1'b1;
        tick();
        Done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk("rst_run",    {31'b0, Run},    32'd0);
        chk("rst_din",    {16'b0, DIN},    32'd0);
        chk("rst_pc",     {28'b0, PC},     32'd0);
        chk("rst_busy",   {31'b0, Busy},   32'd0);
        chk("rst_halted", {31'b0, Halted}, 32'd0);
        chk("rst_erro",   {31'b0, Erro},   32'd0);
        Resetn = 1'b1;
        tick();

        // mvi R0,#5 then halt; Done arrives in the immediate cycle
        load(0, 16'h0040);
        load(1, 16'h0005);
        load(2, 16'h01C0);
        expect_issue(0);
        start_pulse();
        wait_issue("t1_issue");
        chk("t1_busy", {31'b0, Busy}, 32'd1);
        step_done();
        chk("t1_halted", {31'b0, Halted}, 32'd1);
        chk("t1_pc",     {28'b0, PC},     32'd2);
        repeat (3) tick();
        chk("t1_still_halted", {31'b0, Halted}, 32'd1);

        // add with Done delayed 3 cycles; next Run exactly 1 cycle after Done
        load(0, 16'h0080);
        load(1, 16'h0000);
        load(2, 16'h01C0);
        expect_issue(0);
        expect_issue(1);
        start_pulse();
        wait_issue("t2_issue0");
        repeat (3) tick();
        Done = 1'b1;
        tick();
        Done = 1'b0;
        chk("t2_run_after_done", {31'b0, Run}, 32'd1);
        chk("t2_pc1", {28'b0, PC}, 32'd1);
        step_done();
        chk("t2_halted", {31'b0, Halted}, 32'd1);
        chk("t2_pc",     {28'b0, PC},     32'd2);

        // asynchronous reset while waiting in ESPERA
        expect_issue(0);
        start_pulse();
        wait_issue("t3_issue");
        tick();
        tick();
        #2 Resetn = 1'b0;
        #1;
        chk("arst_run",    {31'b0, Run},    32'd0);
        chk("arst_din",    {16'b0, DIN},    32'd0);
        chk("arst_pc",     {28'b0, PC},     32'd0);
        chk("arst_busy",   {31'b0, Busy},   32'd0);
        chk("arst_halted", {31'b0, Halted}, 32'd0);
        tick();
        Resetn = 1'b1;
        tick();
        expect_issue(0);
        expect_issue(1);
        start_pulse();
        wait_issue("arst_reissue");
        step_done();
        step_done();
        chk("arst_halted_after", {31'b0, Halted}, 32'd1);
        chk("arst_pc_after",     {28'b0, PC},     32'd2);

        // end of memory: mvi at the last address is treated as halt
        for (int i = 0; i < 15; i++) load(i, 16'h0000);
        load(15, 16'h0040);
        for (int i = 0; i < 15; i++) expect_issue(i);
        start_pulse();
        for (int i = 0; i < 15; i++) begin
            wait_issue("t4_issue");
            step_done();
        end
        chk("t4_halted", {31'b0, Halted}, 32'd1);
        chk("t4_pc",     {28'b0, PC},     32'd15);
        chk("t4_busy",   {31'b0, Busy},   32'd0);

        // one-word instruction at the last address, then Done
        load(15, 16'h0080);
        for (int i = 0; i < 16; i++) expect_issue(i);
        start_pulse();
        for (int i = 0; i < 16; i++) begin
            wait_issue("t5_issue");
            step_done();
        end
        chk("t5_halted", {31'b0, Halted}, 32'd1);
        chk("t5_pc",     {28'b0, PC},     32'd15);

        // Start and Load_en while Busy are ignored
        load(0, 16'h0080);
        load(1, 16'h01C0);
        expect_issue(0);
        start_pulse();
        wait_issue("t6_issue");
        tick();
        Load_en   = 1'b1;
        Load_addr = '0;
        Load_data = 16'h0FFF;
        Start     = 1'b1;
        tick();
        Load_en   = 1'b0;
        Start     = 1'b0;
        chk("t6_pc_kept",   {28'b0, PC},   32'd0);
        chk("t6_busy_kept", {31'b0, Busy}, 32'd1);
        Done = 1'b1;
        tick();
        Done = 1'b0;
        chk("t6_halted", {31'b0, Halted}, 32'd1);
        chk("t6_pc",     {28'b0, PC},     32'd1);
        expect_issue(0);
        start_pulse();
        wait_issue("t6_mem_kept");
        step_done();
        chk("t6_halted2", {31'b0, Halted}, 32'd1);

        // Load_en and Start in the same cycle issue the written word
        Load_en   = 1'b1;
        Load_addr = '0;
        Load_data = 16'h00C0;
        img[0]    = 16'h00C0;
        Start     = 1'b1;
        expect_issue(0);
        tick();
        Load_en   = 1'b0;
        Start     = 1'b0;
        wait_issue("t7_issue");
        step_done();
        chk("t7_halted", {31'b0, Halted}, 32'd1);
        chk("t7_pc",     {28'b0, PC},     32'd1);

        // Done withheld
        expect_issue(0);
        start_pulse();
        wait_issue("t8_issue");
`ifdef SEQ_WATCHDOG_EN
        repeat (15) tick();
        chk("wd_erro_early", {31'b0, Erro}, 32'd0);
        tick();
        chk("wd_erro",   {31'b0, Erro},   32'd1);
        chk("wd_halted", {31'b0, Halted}, 32'd1);
        expect_issue(0);
        start_pulse();
        chk("wd_erro_cleared", {31'b0, Erro}, 32'd0);
        wait_issue("wd_restart");
        step_done();
`else
        repeat (100) tick();
        chk("nowd_busy",   {31'b0, Busy},   32'd1);
        chk("nowd_erro",   {31'b0, Erro},   32'd0);
        chk("nowd_halted", {31'b0, Halted}, 32'd0);
        step_done();
`endif
        chk("t8_halted", {31'b0, Halted}, 32'd1);
        chk("t8_pc",     {28'b0, PC},     32'd1);

        repeat (3) tick();
        chk("queue_drained", expq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
